// File: rtl/sad_pkg.sv
// Shared mode constants, FSM encoding and width helpers for the SAD/SSD engine.
package sad_pkg;

   localparam logic MODE_SAD = 1'b0;
   localparam logic MODE_SSD = 1'b1;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_READ  = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   function automatic int unsigned sad_clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

   // A squared difference needs twice the pixel width; SAD terms reuse the same register.
   function automatic int unsigned term_width(input int unsigned pix_w);
      return 2 * pix_w;
   endfunction

   function automatic int unsigned lane_sum_width(input int unsigned pix_w,
                                                  input int unsigned pix_per_word);
      return term_width(pix_w) + sad_clog2(pix_per_word);
   endfunction

endpackage

// File: rtl/sad_lane_tree.sv
// Per-lane |a-b| or (a-b)^2 (stage 2) followed by a registered lane adder tree (stage 3).
module sad_lane_tree
   import sad_pkg::*;
#(
   parameter int unsigned PIX_W        = 8,
   parameter int unsigned PIX_PER_WORD = 4
) (
   input  logic                                               Clk,
   input  logic                                               Rst_n,
   input  logic                                               i_mode,
   input  logic                                               i_valid,
   input  logic [PIX_W*PIX_PER_WORD-1:0]                      i_a,
   input  logic [PIX_W*PIX_PER_WORD-1:0]                      i_b,
   output logic                                               o_valid,
   output logic [lane_sum_width(PIX_W, PIX_PER_WORD)-1:0]     o_sum
);

   localparam int unsigned TERM_W = term_width(PIX_W);
   localparam int unsigned SUM_W  = lane_sum_width(PIX_W, PIX_PER_WORD);

   logic [TERM_W-1:0] w_term [PIX_PER_WORD];
   logic [TERM_W-1:0] r_term [PIX_PER_WORD];
   logic              r_v2;
   logic [SUM_W-1:0]  w_sum;
   logic [SUM_W-1:0]  r_sum;
   logic              r_v3;

   for (genvar l = 0; l < PIX_PER_WORD; l++) begin : g_lane
      logic [PIX_W:0]   w_diff;
      logic [PIX_W-1:0] w_abs;

      // One extra bit keeps the sign of the unsigned difference.
      assign w_diff    = {1'b0, i_a[l*PIX_W +: PIX_W]} - {1'b0, i_b[l*PIX_W +: PIX_W]};
      assign w_abs     = w_diff[PIX_W] ? PIX_W'(-w_diff) : w_diff[PIX_W-1:0];
      assign w_term[l] = (i_mode == MODE_SSD) ? TERM_W'(w_abs) * TERM_W'(w_abs)
                                              : TERM_W'(w_abs);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_v2 <= 1'b0;
         for (int l = 0; l < PIX_PER_WORD; l++) r_term[l] <= '0;
      end else begin
         r_v2 <= i_valid;
         for (int l = 0; l < PIX_PER_WORD; l++) r_term[l] <= w_term[l];
      end
   end

   always_comb begin
      w_sum = '0;
      for (int l = 0; l < PIX_PER_WORD; l++) w_sum = w_sum + SUM_W'(r_term[l]);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_v3  <= 1'b0;
         r_sum <= '0;
      end else begin
         r_v3  <= r_v2;
         r_sum <= w_sum;
      end
   end

   assign o_valid = r_v3;
   assign o_sum   = r_sum;

endmodule

// File: rtl/sad_engine_param.sv
// SAD/SSD engine: streams two word memories, accumulates lane sums with saturation.
module sad_engine_param
   import sad_pkg::*;
#(
   parameter int unsigned PIX_W        = 8,
   parameter int unsigned PIX_PER_WORD = 4,
   parameter int unsigned A_WIDTH      = 6,
   parameter int unsigned OUT_W        = 32
) (
   input  logic                          Clk,
   input  logic                          Rst_n,
   input  logic                          Go,
   input  logic                          Mode,
   input  logic [A_WIDTH:0]              Len,
   input  logic [A_WIDTH-1:0]            Base_A,
   input  logic [A_WIDTH-1:0]            Base_B,
   output logic [A_WIDTH-1:0]            MA_Addr,
   output logic                          MA_En,
   input  logic [PIX_W*PIX_PER_WORD-1:0] MA_Do,
   output logic [A_WIDTH-1:0]            MB_Addr,
   output logic                          MB_En,
   input  logic [PIX_W*PIX_PER_WORD-1:0] MB_Do,
   output logic                          Busy,
   output logic                          Done,
   output logic [OUT_W-1:0]              SAD_Out,
   output logic                          Overflow
);

   localparam int unsigned SUM_W = lane_sum_width(PIX_W, PIX_PER_WORD);
   localparam int unsigned EXT_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;

   state_t             r_state;
   logic               r_mode;
   logic [A_WIDTH:0]   r_len;
   logic [A_WIDTH:0]   r_cnt;
   logic [1:0]         r_drain;
   logic [A_WIDTH-1:0] r_ma_addr;
   logic [A_WIDTH-1:0] r_mb_addr;
   logic               r_en;
   logic               r_v1;
   logic [OUT_W-1:0]   r_acc;
   logic               r_ovf;
   logic [OUT_W-1:0]   r_sad;
   logic               r_ovf_out;
   logic               r_busy;
   logic               r_done;

   logic               w_start;
   logic               w_lane_v;
   logic [SUM_W-1:0]   w_lane_sum;
   logic [EXT_W-1:0]   w_ext;
   logic               w_sat;
   logic [OUT_W-1:0]   w_acc_next;

   assign w_start = Go && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   sad_lane_tree #(
      .PIX_W        (PIX_W),
      .PIX_PER_WORD (PIX_PER_WORD)
   ) u_lane_tree (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .i_mode  (r_mode),
      .i_valid (r_v1),
      .i_a     (MA_Do),
      .i_b     (MB_Do),
      .o_valid (w_lane_v),
      .o_sum   (w_lane_sum)
   );

   // Sequencer: word 0 is issued on the Go edge itself, the rest from READ.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state   <= ST_IDLE;
         r_mode    <= MODE_SAD;
         r_len     <= '0;
         r_cnt     <= '0;
         r_drain   <= '0;
         r_ma_addr <= '0;
         r_mb_addr <= '0;
         r_en      <= 1'b0;
      end else if (w_start) begin
         r_mode    <= Mode;
         r_len     <= Len;
         r_ma_addr <= Base_A;
         r_mb_addr <= Base_B;
         if (Len != '0) begin
            r_en    <= 1'b1;
            r_cnt   <= (A_WIDTH+1)'(1);
            r_state <= ST_READ;
         end else begin
            r_state <= ST_DONE;
         end
      end else begin
         case (r_state)
            ST_READ: begin
               if (r_cnt == r_len) begin
                  r_en    <= 1'b0;
                  r_drain <= '0;
                  r_state <= ST_DRAIN;
               end else begin
                  r_ma_addr <= r_ma_addr + A_WIDTH'(1);
                  r_mb_addr <= r_mb_addr + A_WIDTH'(1);
                  r_cnt     <= r_cnt + (A_WIDTH+1)'(1);
               end
            end
            // Three cycles cover memory, term and tree stages of the last word.
            ST_DRAIN: begin
               if (r_drain == 2'd2) r_state <= ST_DONE;
               else                 r_drain <= r_drain + 2'd1;
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) r_v1 <= 1'b0;
      else        r_v1 <= r_en;
   end

   assign w_ext      = EXT_W'(r_acc) + EXT_W'(w_lane_sum);
   assign w_sat      = |w_ext[EXT_W-1:OUT_W];
   assign w_acc_next = w_sat ? {OUT_W{1'b1}} : w_ext[OUT_W-1:0];

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
      end else if (w_start) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
      end else if (w_lane_v) begin
         r_acc <= w_acc_next;
         r_ovf <= r_ovf | w_sat;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_done    <= 1'b0;
         r_sad     <= '0;
         r_ovf_out <= 1'b0;
      end else if (r_state == ST_DONE) begin
         r_done    <= 1'b1;
         r_sad     <= r_acc;
         r_ovf_out <= r_ovf;
      end else begin
         r_done    <= 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)                   r_busy <= 1'b0;
      else if (w_start)             r_busy <= 1'b1;
      else if (r_state == ST_DONE)  r_busy <= 1'b0;
   end

   assign MA_Addr  = r_ma_addr;
   assign MB_Addr  = r_mb_addr;
   assign MA_En    = r_en;
   assign MB_En    = r_en;
   assign Busy     = r_busy;
   assign Done     = r_done;
   assign SAD_Out  = r_sad;
   assign Overflow = r_ovf_out;

endmodule

// File: doc/sad_engine_param.md
Name: sad_engine_param

Overview:
Parametrised successor to the fixed 8-bit, 4-pixel, 64-word SAD core.
- Streams two blocks from external synchronous-read word memories A and B (1-cycle read latency).
- Computes the sum of absolute differences (SAD) or the sum of squared differences (SSD) over a run-time length and run-time base addresses.
- Pipelined datapath with a saturating accumulator, Go/Done handshake and Busy status.
- Sits between the MA/MB memories and the top-level control of the SAD_Top successor.

Parameters:
- PIX_W, 8, bits per pixel
- PIX_PER_WORD, 4, pixels packed per memory word; lane 0 is the LSBs
- A_WIDTH, 6, word-address width; memory depth is 2**A_WIDTH
- OUT_W, 32, accumulator and result width

Ports:
- Clk  in  1  sole clock; all state updates on the rising edge
- Rst_n  in  1  reset, asynchronous assert, active-low
- Go  in  1  start request, sampled on a rising edge
- Mode  in  1  0 = SAD, 1 = SSD; latched at Go
- Len  in  A_WIDTH+1  words to process, 0..2**A_WIDTH; latched at Go
- Base_A  in  A_WIDTH  start word address in memory A; latched at Go
- Base_B  in  A_WIDTH  start word address in memory B; latched at Go
- MA_Addr  out  A_WIDTH  memory A read address, registered
- MA_En  out  1  memory A read enable, registered
- MA_Do  in  PIX_W*PIX_PER_WORD  memory A read data
- MB_Addr  out  A_WIDTH  memory B read address, registered
- MB_En  out  1  memory B read enable, registered
- MB_Do  in  PIX_W*PIX_PER_WORD  memory B read data
- Busy  out  1  high from the accepted Go until Done
- Done  out  1  one-cycle pulse; SAD_Out is valid in that cycle
- SAD_Out  out  OUT_W  result, held until the next Done
- Overflow  out  1  set when the run's accumulator saturated; updated with SAD_Out

Behaviour:
- Reset (Rst_n=0, asynchronous): all outputs 0, FSM to IDLE, accumulator 0, pipeline valids 0. Reset mid-run aborts the run; no Done is produced.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: Go=1 latches Mode, Len, Base_A and Base_B, clears the accumulator and sticky overflow, sets Busy. Next state is READ if Len!=0, otherwise DONE.
  - READ: issues one address pair per cycle, MA_Addr = Base_A+i and MB_Addr = Base_B+i for i = 0..Len-1, with MA_En = MB_En = 1. Addresses wrap modulo 2**A_WIDTH. After the last issue the state goes to DRAIN and En drops to 0.
  - DRAIN: waits until the last word has been accumulated (3 cycles), then goes to DONE.
  - DONE: Done=1 for one cycle. SAD_Out and Overflow load from the accumulator, Busy clears. Next state is IDLE. Go=1 in this cycle is accepted as a new start, as if in IDLE.
- Go while in READ or DRAIN is ignored.
- Pipeline, with Go sampled at edge E:
  - Address i is valid after edge E+i.
  - Memory data for word i is valid after edge E+1+i.
  - Per-lane |a-b| (PIX_W bits) or (a-b)^2 (2*PIX_W bits) is registered at edge E+2+i.
  - Lane adder-tree sum (term width + clog2(PIX_PER_WORD) bits) is registered at E+3+i.
  - Accumulation happens at E+4+i.
  - Done is high after edge E+Len+4. Len=64 gives Done 68 cycles after Go.
  - Len=0: Done is high after edge E+1; SAD_Out=0, Overflow=0.
- Arithmetic:
  - All pixel values are unsigned; each difference is computed with one extra bit to form the absolute value.
  - The lane sum is zero-extended to OUT_W.
  - Accumulator saturates at 2**OUT_W-1 and sets a sticky overflow flag for the run.
- SAD_Out is unchanged outside Done loads, including during a new run.

Decomposition:
- Shared package sad_pkg holds:
  - the mode constants MODE_SAD and MODE_SSD;
  - the FSM state encoding;
  - width functions: term width, lane-sum width, clog2.
- One sub-module, sad_lane_tree: per-lane abs-diff/square plus the registered adder tree, parametrised by PIX_W, PIX_PER_WORD and Mode. It holds the stage-2 and stage-3 registers.
- The FSM, address generation and accumulator remain in sad_engine_param.

Test Plan:
1. A=0x01010101, B=0x00000000 in all 64 words; Go with Mode=0, Len=64, bases 0 -> Done after 68 cycles, SAD_Out=0x100, Overflow=0, Busy high for 68 cycles.
2. A=0x00000000, B=0xFFFFFFFF; Mode=0, Len=64 -> SAD_Out=0xFF00 (absolute value is symmetric). Then A=0x03030303, B=0, Mode=1 -> SAD_Out=0x900.
3. Len=0 -> Done 1 cycle after Go, SAD_Out=0, MA_En never asserted. Go pulsed in the same cycle as Done -> second run starts and its result appears Len+4 cycles later.
4. Base_A=60, Base_B=0, Len=8 -> MA_Addr sequence 60,61,62,63,0,1,2,3 on consecutive cycles. Result equals a software model over those words.
5. OUT_W=16, A=0xFFFFFFFF, B=0, Mode=1, Len=64 -> SAD_Out=0xFFFF, Overflow=1. Next run with no overflow -> Overflow returns to 0.
6. Rst_n pulled low at cycle 20 of a 64-word run -> all outputs 0 immediately, no Done. A fresh Go afterwards gives the correct result.
